ex_xmit: RTL
============

# ex_xmit

Transmit side of the EX pipeline-latch interface. Accepts packed 270-bit instruction bundles from the address-generation stage, buffers up to two in a skid buffer, and presents one bundle per cycle to the EX latch. Honours the latch's `stall`, and back-pressures the upstream stage with a combinational `up_stall`. Sits between the AG stage output and the EX latch input.

## Interface
- `W`, default 270: bundle width.
  - Bit 0 is the valid bit.
  - Bits [4:1] are `br_fetchID`.
  - Bits [269:221] are the control store word.
- `DEPTH`, default 2: buffer entries. Fixed at 2; other values are unsupported.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  W  bundle from AG. `in_data[0]` is the upstream valid.
- `up_stall`  out  1  back-pressure to AG. High means AG must hold `in_data`.
- `out_data`  out  W  bundle driven into the EX latch input.
- `stall`  in  1  EX latch hold. High means the latch did not capture this cycle.
- `flush`  in  1  squash request. Present only with `EX_XMIT_FLUSH_EN`.
- `count`  out  2  current occupancy (0..2), for debug and verification.

## Operation
- Storage: two W-bit slots, plus a 1-bit write pointer, a 1-bit read pointer and a 2-bit count.
- Push occurs when `in_data[0] && !up_stall`. The bundle is written to `slot[wr_ptr]` and `wr_ptr` toggles.
- Pop occurs when `count != 0 && !stall`. `rd_ptr` toggles.
- Push and pop in the same cycle leave `count` unchanged. Both pointers advance.
- `up_stall = (count == 2)`, combinational from the registered count.
- `out_data`:
  - When `count != 0`, it is `slot[rd_ptr]` with bit 0 forced to 1.
  - When `count == 0`, it is all zeros. The EX latch therefore captures a bubble with valid = 0.
- A bundle arriving with `in_data[0] == 0` is never stored.
- Full (`count == 2`): no push is possible because `up_stall` is high. A pop that cycle drops `count` to 1, and `up_stall` falls the next cycle.
- Empty (`count == 0`): no pop occurs even if `stall` is low. A push that cycle makes `count` 1.
- Pointer wrap: 1-bit pointers wrap naturally (1 -> 0).
- The block never reorders, duplicates or drops a valid bundle, except on flush.

## Timing
- Latency: 1 cycle. A bundle pushed in cycle N appears on `out_data` in cycle N+1.
- Throughput: 1 bundle/cycle at `count == 1` with `stall` low.
- `out_data` is stable for as long as `stall` is high. It changes only after a pop.
- Reset values:
  - `count = 0`, `wr_ptr = 0`, `rd_ptr = 0`.
  - Slots cleared to 0.
  - `out_data = 0`, `up_stall = 0`.
- Reset asserted mid-operation clears all state immediately (asynchronously). Buffered bundles are lost.
- Combinational paths:
  - `up_stall` and `out_data` depend on registers only.
  - `stall` and `in_data` affect only next-state logic.

## Configuration
- Macro: `EX_XMIT_FLUSH_EN`.
- Defined:
  - The `flush` port exists.
  - `flush` high at a rising edge sets `count = 0`, resets both pointers to 0 and discards any same-cycle push.
  - Flush has priority over push and pop.
  - `out_data` is 0 in the following cycle.
- Not defined:
  - There is no `flush` port.
  - Squashing is the downstream stage's job, using `br_fetchID`.

## Structure
- Shared package `ex_pkg`:
  - `EX_BUNDLE_W = 270`.
  - Field offsets: `EX_V_BIT = 0`, `EX_FETCHID_LSB = 1`, `EX_CS_LSB = 221`, and the other field LSB/MSB constants.
  - Typedef `ex_bundle_t` (packed, 270 bits).
- One sub-module, `ex_xmit_slots`: two-entry register file with a write port (`we`, `waddr`, `wdata`) and an asynchronous read port (`raddr`, `rdata`).
- Pointer/count control stays in `ex_xmit`.

## Test plan
- Reset: assert `rst` with `count == 2` -> `count = 0`, `out_data = 0`, `up_stall = 0` immediately, without waiting for a clock edge.
- Streaming: bundles A = 0x...1, B = 0x...3, C = 0x...5 pushed on consecutive cycles with `stall = 0` -> `out_data` shows A, B, C in cycles 1, 2, 3; `count` stays 1.
- Back-pressure: hold `stall = 1` and push A, B -> `count = 2`, `up_stall = 1`, `out_data = A` held. Drop `stall` -> A then B emitted; `up_stall` falls one cycle after the first pop.
- Simultaneous push and pop at `count == 1` -> `count` stays 1; order is preserved across pointer wrap for 8 consecutive bundles.
- Invalid input: `in_data[0] = 0` with a nonzero payload -> no push; `count` is unchanged; `out_data = 0` when empty.
- Flush (`EX_XMIT_FLUSH_EN`): `count = 2`, then pulse `flush` together with a push -> next cycle `count = 0` and `out_data = 0`; a subsequent push D appears one cycle later.

Source files
------------

// File: rtl/ex_xmit_pkg.sv
// Shared EX-bundle definitions: bundle width, field offsets and bundle type.
package ex_pkg;

  localparam int EX_BUNDLE_W    = 270;
  localparam int EX_V_BIT       = 0;
  localparam int EX_FETCHID_LSB = 1;
  localparam int EX_FETCHID_MSB = 4;
  localparam int EX_PAYLOAD_LSB = 5;
  localparam int EX_PAYLOAD_MSB = 220;
  localparam int EX_CS_LSB      = 221;
  localparam int EX_CS_MSB      = 269;

  typedef logic [EX_BUNDLE_W-1:0] ex_bundle_t;

  function automatic logic ex_is_valid(input ex_bundle_t b);
    return b[EX_V_BIT];
  endfunction

endpackage

// File: rtl/ex_xmit_slots.sv
// Two-entry bundle register file: one synchronous write port, one asynchronous read port.
module ex_xmit_slots
  import ex_pkg::*;
#(
  parameter int W = EX_BUNDLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         waddr,
  input  logic [W-1:0] wdata,
  input  logic         raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] slot0_r;
  logic [W-1:0] slot1_r;

  // Slot storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_r <= '0;
      slot1_r <= '0;
    end else if (we) begin
      if (waddr) begin
        slot1_r <= wdata;
      end else begin
        slot0_r <= wdata;
      end
    end
  end

  // Asynchronous read mux.
  always_comb begin
    rdata = slot0_r;
    if (raddr) begin
      rdata = slot1_r;
    end else begin
      rdata = slot0_r;
    end
  end

endmodule

// File: rtl/ex_xmit.sv
// EX latch transmit skid buffer: two-entry in-order bundle queue with back-pressure.
// Optional squash input enabled by defining EX_XMIT_FLUSH_EN.
module ex_xmit
  import ex_pkg::*;
#(
  parameter int W     = EX_BUNDLE_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  output logic         up_stall,
  output logic [W-1:0] out_data,
  input  logic         stall,
`ifdef EX_XMIT_FLUSH_EN
  input  logic         flush,
`endif
  output logic [1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic [W-1:0]     rdata_s;

`ifdef EX_XMIT_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign up_stall = (count_r == 2'd2);
  assign push_s   = in_data[EX_V_BIT] && !up_stall;
  assign pop_s    = (count_r != 2'd0) && !stall;
  assign count    = count_r;

  ex_xmit_slots #(.W(W)) u_slots (
    .clk   (clk),
    .rst   (rst),
    .we    (push_s && !flush_s),
    .waddr (wr_ptr_r),
    .wdata (in_data),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Pointer and occupancy control; flush beats both push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 2'd0;
    end else if (flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head bundle with valid forced high; a zero bubble when empty.
  always_comb begin
    out_data = '0;
    if (count_r != 2'd0) begin
      out_data = rdata_s | {{(W-1){1'b0}}, 1'b1};
    end else begin
      out_data = '0;
    end
  end

endmodule
